// File: rtl/jump_ctrl_pkg.sv
// Shared types and default sizing for the jump control unit.
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    JOP_NONE  = 2'd0,
    JOP_JCOND = 2'd1,
    JOP_CALL  = 2'd2,
    JOP_RET   = 2'd3
  } jop_t;

  localparam int unsigned DefD        = 12;
  localparam int unsigned DefLutAw    = 5;
  localparam int unsigned DefRasDepth = 4;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of Width-bit entries; push when full / pop when empty are ignored.
module ras_stack #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [Width-1:0]             push_data,
  output logic [Width-1:0]             top,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] entries_q [Depth];
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;

  assign full     = (count_q == CW'(Depth));
  assign empty    = (count_q == '0);
  assign push_idx = AW'(count_q);
  assign top_idx  = AW'(count_q - CW'(1));
  assign top      = empty ? '0 : entries_q[top_idx];
  assign count    = count_q;

  // Popped entries are left in place; only count_q defines the live region.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
    end else if (push && !full) begin
      entries_q[push_idx] <= push_data;
      count_q             <= count_q + CW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow unit feeding the PC: same-cycle jump decode with a loadable target LUT and a RAS.
module jump_ctrl
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned D         = DefD,
  parameter int unsigned LUT_AW    = DefLutAw,
  parameter int unsigned RAS_DEPTH = DefRasDepth
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [D-1:0]                     prog_ctr,
  input  jop_t                             jump_op,
  input  logic                             cond_flag,
  input  logic [LUT_AW-1:0]                lut_idx,
  input  logic                             lut_we,
  input  logic [LUT_AW-1:0]                lut_waddr,
  input  logic [D-1:0]                     lut_wdata,
  input  logic                             clr_flags,
  output logic                             absjump_en,
  output logic [D-1:0]                     target,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int unsigned LutSize = 2 ** LUT_AW;

  logic [D-1:0] lut_q [LutSize];
  logic [D-1:0] ras_top;
  logic         ras_full;
  logic         ras_empty;
  logic         push;
  logic         pop;
  logic         take;
  logic [D-1:0] tgt;
  logic         ovf_set;
  logic         unf_set;
  logic         ovf_q;
  logic         unf_q;

  always_comb begin
    take    = 1'b0;
    tgt     = '0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (jump_op)
      JOP_NONE: ;
      JOP_JCOND: begin
        if (cond_flag) begin
          take = 1'b1;
          tgt  = lut_q[lut_idx];
        end
      end
      JOP_CALL: begin
        if (ras_full) begin
          ovf_set = 1'b1;
        end else begin
          take = 1'b1;
          tgt  = lut_q[lut_idx];
          push = 1'b1;
        end
      end
      JOP_RET: begin
        if (ras_empty) begin
          unf_set = 1'b1;
        end else begin
          take = 1'b1;
          tgt  = ras_top;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of any clock edge.
  assign absjump_en = reset & take;
  assign target     = reset ? tgt : '0;

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LutSize; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // A set event in the same cycle as a clear keeps the flag high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_flags);
      unf_q <= unf_set | (unf_q & ~clr_flags);
    end
  end

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  ras_stack #(
    .Width (D),
    .Depth (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (prog_ctr + D'(1)),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl with a queue of expected output snapshots.
module tb_jump_ctrl;
  import jump_ctrl_pkg::*;

  typedef struct {
    string       tag;
    logic        en;
    logic [11:0] tgt;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  jop_t        jump_op;
  logic        cond_flag;
  logic [4:0]  lut_idx;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic        clr_flags;
  logic        absjump_en;
  logic [11:0] target;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jump_ctrl #(
    .D         (12),
    .LUT_AW    (5),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .prog_ctr      (prog_ctr),
    .jump_op       (jump_op),
    .cond_flag     (cond_flag),
    .lut_idx       (lut_idx),
    .lut_we        (lut_we),
    .lut_waddr     (lut_waddr),
    .lut_wdata     (lut_wdata),
    .clr_flags     (clr_flags),
    .absjump_en    (absjump_en),
    .target        (target),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input logic [11:0] tgt,
                            input logic [2:0] cnt, input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag; e.en = en; e.tgt = tgt; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".en"},  {11'd0, absjump_en},    {11'd0, e.en});
    cmp({e.tag, ".tgt"}, target,                 e.tgt);
    cmp({e.tag, ".cnt"}, {9'd0, ras_count},      {9'd0, e.cnt});
    cmp({e.tag, ".ovf"}, {11'd0, ras_overflow},  {11'd0, e.ovf});
    cmp({e.tag, ".unf"}, {11'd0, ras_underflow}, {11'd0, e.unf});
  endtask

  task automatic drive(input jop_t op, input logic cond, input logic [4:0] idx,
                       input logic [11:0] pc, input logic clr);
    jump_op = op; cond_flag = cond; lut_idx = idx; prog_ctr = pc; clr_flags = clr;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [11:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
  endtask

  // Called at a negedge with inputs driven and expectation queued; returns at the next negedge.
  task automatic finish_step();
    #2;
    sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset with random inputs: outputs must be quiet before any clock edge.
    reset     = 1'b0;
    jump_op   = jop_t'($urandom_range(0, 3));
    cond_flag = 1'($urandom);
    lut_idx   = 5'($urandom);
    prog_ctr  = 12'($urandom);
    lut_we    = 1'($urandom);
    lut_waddr = 5'($urandom);
    lut_wdata = 12'($urandom);
    clr_flags = 1'($urandom);
    expect_out("reset", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
    #3;
    sample();
    @(negedge clk);
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    reset = 1'b1;

    // LUT load and conditional jumps
    wr(5'd3, 12'h0A5);
    expect_out("lutwr", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_JCOND, 1'b1, 5'd3, 12'h000, 1'b0);
    expect_out("jc_t", 1'b1, 12'h0A5, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_JCOND, 1'b1, 5'd3, 12'h000, 1'b0); wr(5'd3, 12'h3C3);
    expect_out("jc_old", 1'b1, 12'h0A5, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_JCOND, 1'b1, 5'd3, 12'h000, 1'b0);
    expect_out("jc_new", 1'b1, 12'h3C3, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_JCOND, 1'b0, 5'd3, 12'h000, 1'b0);
    expect_out("jc_nt", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();

    // Nested call/return
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0); wr(5'd1, 12'h100);
    expect_out("wr1", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0); wr(5'd2, 12'h200);
    expect_out("wr2", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_CALL, 1'b0, 5'd1, 12'h010, 1'b0);
    expect_out("call1", 1'b1, 12'h100, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_CALL, 1'b0, 5'd2, 12'h104, 1'b0);
    expect_out("call2", 1'b1, 12'h200, 3'd1, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("cnt2", 1'b0, 12'h000, 3'd2, 1'b0, 1'b0); finish_step();
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("ret1", 1'b1, 12'h105, 3'd2, 1'b0, 1'b0); finish_step();
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("ret2", 1'b1, 12'h011, 3'd1, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("cnt0", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();

    // Underflow and clear
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("unf_ret", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("unf_set", 1'b0, 12'h000, 3'd0, 1'b0, 1'b1); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b1);
    expect_out("unf_clr", 1'b0, 12'h000, 3'd0, 1'b0, 1'b1); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("unf_off", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();

    // Fill the stack, then overflow
    for (int i = 0; i < 4; i++) begin
      drive(JOP_CALL, 1'b0, 5'd1, 12'h020 + 12'(i), 1'b0);
      expect_out($sformatf("fill%0d", i), 1'b1, 12'h100, 3'(i), 1'b0, 1'b0); finish_step();
    end
    drive(JOP_CALL, 1'b0, 5'd2, 12'h030, 1'b0);
    expect_out("ovf_call", 1'b0, 12'h000, 3'd4, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("ovf_set", 1'b0, 12'h000, 3'd4, 1'b1, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b1);
    expect_out("ovf_clr", 1'b0, 12'h000, 3'd4, 1'b1, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("ovf_off", 1'b0, 12'h000, 3'd4, 1'b0, 1'b0); finish_step();
    drive(JOP_CALL, 1'b0, 5'd2, 12'h031, 1'b1);
    expect_out("ovf_clrset", 1'b0, 12'h000, 3'd4, 1'b0, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("ovf_wins", 1'b0, 12'h000, 3'd4, 1'b1, 1'b0); finish_step();
    drive(JOP_NONE, 1'b0, 5'd0, 12'h000, 1'b1);
    expect_out("ovf_clr2", 1'b0, 12'h000, 3'd4, 1'b1, 1'b0); finish_step();

    // Drain in LIFO order
    for (int i = 0; i < 4; i++) begin
      drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
      expect_out($sformatf("drain%0d", i), 1'b1, 12'h024 - 12'(i), 3'(4 - i), 1'b0, 1'b0);
      finish_step();
    end

    // PC wrap on call
    drive(JOP_CALL, 1'b0, 5'd2, 12'hFFF, 1'b0);
    expect_out("wrap_call", 1'b1, 12'h200, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("wrap_ret", 1'b1, 12'h000, 3'd1, 1'b0, 1'b0); finish_step();

    // Mid-sequence reset with two entries on the stack
    drive(JOP_CALL, 1'b0, 5'd1, 12'h050, 1'b0);
    expect_out("mr_call1", 1'b1, 12'h100, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_CALL, 1'b0, 5'd1, 12'h060, 1'b0);
    expect_out("mr_call2", 1'b1, 12'h100, 3'd1, 1'b0, 1'b0); finish_step();
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    expect_out("mr_rst", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    sample();
    @(negedge clk);
    drive(JOP_RET, 1'b0, 5'd0, 12'h000, 1'b0);
    reset = 1'b1;
    expect_out("mr_ret", 1'b0, 12'h000, 3'd0, 1'b0, 1'b0); finish_step();
    drive(JOP_JCOND, 1'b1, 5'd1, 12'h000, 1'b0);
    expect_out("mr_lut", 1'b1, 12'h000, 3'd0, 1'b0, 1'b1); finish_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
Control-flow unit directly upstream of the program counter. Each cycle it decodes the current control-flow op and drives the PC's absjump_en and target inputs in the same cycle, so there are no branch delay slots. It owns a loadable jump-target lookup table (LUT) and a return-address stack (RAS) that supports call and return.

Parameters:
D, 12, PC/target width; matches the PC width.
LUT_AW, 5, jump LUT index width; the LUT has 2**LUT_AW entries.
RAS_DEPTH, 4, return-address stack entries (>=1).

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
prog_ctr  input  D  PC value of the instruction currently executing.
jump_op  input  2  jop_t: JOP_NONE=0, JOP_JCOND=1, JOP_CALL=2, JOP_RET=3.
cond_flag  input  1  branch condition for JOP_JCOND.
lut_idx  input  LUT_AW  LUT index for JCOND/CALL.
lut_we  input  1  LUT write enable.
lut_waddr  input  LUT_AW  LUT write index.
lut_wdata  input  D  LUT write data.
clr_flags  input  1  clears the sticky error flags.
absjump_en  output  1  to PC: take target next edge.
target  output  D  to PC: jump destination.
ras_count  output  $clog2(RAS_DEPTH+1)  current RAS occupancy.
ras_overflow  output  1  sticky: a call was attempted while the RAS was full.
ras_underflow  output  1  sticky: a return was attempted while the RAS was empty.

Behaviour:
- Reset (reset=0, async):
  - All LUT entries, RAS entries and ras_count go to 0; both flags go to 0.
  - absjump_en=0 and target=0 while reset is low.
- Output path: absjump_en and target are combinational from jump_op, cond_flag, lut_idx, the LUT contents and the RAS top. Zero-cycle latency to the PC.
- State (LUT, RAS, count, flags) updates only on posedge clk while reset=1.
- When absjump_en=0, target is driven to 0 (deterministic, no X).
- JOP_NONE: absjump_en=0; no state change.
- JOP_JCOND:
  - absjump_en=cond_flag.
  - If taken, target=lut[lut_idx]; otherwise 0.
  - No RAS change.
- JOP_CALL, RAS not full:
  - absjump_en=1, target=lut[lut_idx].
  - Push (prog_ctr+1) mod 2**D; ras_count increments.
- JOP_CALL, RAS full:
  - absjump_en=0 (call dropped, PC falls through); no push.
  - ras_overflow set.
- JOP_RET, count>0:
  - absjump_en=1, target=RAS top entry.
  - Pop; ras_count decrements.
- JOP_RET, count==0:
  - absjump_en=0; no state change except ras_underflow set.
- RAS is a true LIFO: nested calls return in reverse order. Entries above the top are don't-care and are not cleared on pop.
- LUT write:
  - On posedge with lut_we=1, lut[lut_waddr] <= lut_wdata.
  - A same-cycle read of the same index returns the OLD value; the new value is visible from the next cycle.
  - LUT writes are independent of jump_op; they may coincide with any op.
- Flags:
  - Sticky until clr_flags=1 at a posedge.
  - A set event in the same cycle as clr_flags wins, so the flag stays 1.
- Wrap: prog_ctr = 2**D-1 on a call pushes 0.
- Reset asserted mid-sequence (e.g. with the RAS half full) discards all state immediately; there is no flush handshake.

Decomposition:
- Package jump_ctrl_pkg holds:
  - jop_t enum (2-bit) with JOP_NONE/JCOND/CALL/RET.
  - Default localparams for D, LUT_AW and RAS_DEPTH.
- One sub-module, ras_stack:
  - Inputs: push, pop, push_data.
  - Outputs: top, count, full, empty.
  - Async active-low reset; push when full and pop when empty are ignored internally.
- The LUT and the op decode stay in jump_ctrl.

Test Plan:
- Reset then idle: hold reset=0 mid-cycle with random inputs -> absjump_en=0, target=0, ras_count=0, flags=0 immediately, without waiting for a clock edge.
- LUT load/JCOND: write lut[3]=12'h0A5; next cycle JCOND idx=3, cond=1 -> absjump_en=1, target=0x0A5; with cond=0 -> absjump_en=0, target=0. Write and read idx 3 in the same cycle -> old value.
- Call/return nesting: lut[1]=0x100, lut[2]=0x200.
  - CALL idx1 at pc=0x010 -> target 0x100, count=1.
  - CALL idx2 at pc=0x104 -> target 0x200, count=2.
  - RET -> target 0x105, count=1.
  - RET -> target 0x011, count=0.
- Overflow: 4 calls then a 5th -> 5th has absjump_en=0, ras_overflow=1, count stays 4. Clear with clr_flags -> 0. Overflow event in the same cycle as clr_flags -> flag stays 1.
- Underflow: RET with count=0 -> absjump_en=0, ras_underflow=1, count=0.
- Wrap and mid-op reset:
  - CALL at pc=0xFFF, then RET -> target 0x000.
  - Push 2 entries, pulse reset low -> count=0; a subsequent RET underflows.
